// File: rtl/mem_rw_arbiter_if.sv
// Requester-side bundle of the memory arbiter: N_REQ request channels and their response channels.
interface mem_rw_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*64-1:0] req_index;
  logic [N_REQ*64-1:0] req_wdata;
  logic [N_REQ*64-1:0] req_wmask;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [N_REQ*64-1:0] rsp_data;
  logic [N_REQ-1:0]    rsp_err;

  modport master (
    output req_valid, req_write, req_index, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_index, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_rw_arbiter.sv
// Round-robin sharing of one 64-bit memory read/write port among N_REQ requesters; issue in the grant cycle, response next cycle.
// A response not taken is held per slot until rsp_ready, and that requester is not granted again until its slot is free.
module mem_rw_arbiter #(
  parameter int          N_REQ     = 2,
  parameter logic [63:0] RAM_WORDS = 64'd536870912
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_rw_arbiter_if.slave      bus,
  output logic                 mem_enable,
  output logic                 mem_r_enable,
  output logic [63:0]          mem_r_index,
  input  logic [63:0]          mem_r_data,
  output logic                 mem_w_enable,
  output logic [63:0]          mem_w_index,
  output logic [63:0]          mem_w_data,
  output logic [63:0]          mem_w_mask,
  output logic [31:0]          err_count
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {FREE, INFLIGHT, HELD} slot_e;

  slot_e             state     [N_REQ];
  logic [N_REQ-1:0]  slot_rd;
  logic [N_REQ-1:0]  slot_err;
  logic [63:0]       held_data [N_REQ];
  logic [PW-1:0]     rr_ptr;
  logic [31:0]       err_cnt;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic              any_grant;
  logic [PW-1:0]     win;
  logic              win_write;
  logic              win_oor;
  logic [63:0]       win_index;
  logic [63:0]       win_wdata;
  logic [63:0]       win_wmask;
  logic [63:0]       rsp_word  [N_REQ];

  assign mem_enable = reset;
  assign err_count  = err_cnt;

  // Round-robin search from rr_ptr; slots that free this cycle are still busy here.
  always_comb begin
    int idx;
    idx       = 0;
    eligible  = '0;
    grant     = '0;
    any_grant = 1'b0;
    win       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = reset && bus.req_valid[i] && (state[i] == FREE);
    end
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_grant && eligible[idx]) begin
        any_grant = 1'b1;
        win       = PW'(idx);
      end
    end
    if (any_grant) grant[win] = 1'b1;
  end

  always_comb begin
    win_write = bus.req_write[win];
    win_index = bus.req_index[int'(win)*64 +: 64];
    win_wdata = bus.req_wdata[int'(win)*64 +: 64];
    win_wmask = bus.req_wmask[int'(win)*64 +: 64];
    win_oor   = (win_index >= RAM_WORDS);
  end

  always_comb begin
    mem_r_enable = any_grant && !win_write && !win_oor;
    mem_w_enable = any_grant && win_write && !win_oor;
    mem_r_index  = mem_r_enable ? win_index : '0;
    mem_w_index  = mem_w_enable ? win_index : '0;
    mem_w_data   = mem_w_enable ? win_wdata : '0;
    mem_w_mask   = mem_w_enable ? win_wmask : '0;
  end

  always_comb begin
    bus.req_ready = grant;
    bus.rsp_valid = '0;
    bus.rsp_err   = '0;
    bus.rsp_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_word[i] = '0;
      case (state[i])
        INFLIGHT: rsp_word[i] = slot_rd[i] ? mem_r_data : '0;
        HELD:     rsp_word[i] = held_data[i];
        default:  rsp_word[i] = '0;
      endcase
      bus.rsp_valid[i]           = (state[i] != FREE);
      bus.rsp_err[i]             = (state[i] != FREE) && slot_err[i];
      bus.rsp_data[i*64 +: 64]   = rsp_word[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        state[i]     <= FREE;
        held_data[i] <= '0;
      end
      slot_rd  <= '0;
      slot_err <= '0;
      rr_ptr   <= '0;
      err_cnt  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case (state[i])
          FREE: begin
            if (grant[i]) begin
              state[i]    <= INFLIGHT;
              slot_rd[i]  <= !win_write && !win_oor;
              slot_err[i] <= win_oor;
            end
          end
          INFLIGHT: begin
            // Read data is only valid for this one cycle, so capture it if not consumed.
            if (bus.rsp_ready[i]) begin
              state[i] <= FREE;
            end else begin
              state[i]     <= HELD;
              held_data[i] <= rsp_word[i];
            end
          end
          HELD: begin
            if (bus.rsp_ready[i]) state[i] <= FREE;
          end
          default: state[i] <= FREE;
        endcase
      end
      if (any_grant) begin
        rr_ptr <= (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);
      end
      if (any_grant && win_oor && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed bench for mem_rw_arbiter with a request/response model checked every cycle and literal spot checks.
module tb_mem_rw_arbiter;
  localparam int          N  = 2;
  localparam logic [63:0] RW = 64'd536870912;
  localparam logic [63:0] PRE_IDX [5] = '{64'd3, 64'd5, 64'h10, 64'h20, 64'h21};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_enable, mem_r_enable, mem_w_enable;
  logic [63:0] mem_r_index, mem_w_index, mem_w_data, mem_w_mask;
  logic [63:0] mem_r_data = '0;
  logic [31:0] err_count;
  logic        ld_en = 1'b0;
  logic [63:0] ld_idx = '0;
  logic        preset_now = 1'b0;
  logic [63:0] ram [0:255];
  logic [63:0] ref_mem [longint unsigned];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  mem_rw_arbiter_if #(.N_REQ(N)) bus ();

  mem_rw_arbiter #(.N_REQ(N), .RAM_WORDS(RW)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .mem_enable(mem_enable), .mem_r_enable(mem_r_enable), .mem_r_index(mem_r_index),
    .mem_r_data(mem_r_data), .mem_w_enable(mem_w_enable), .mem_w_index(mem_w_index),
    .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask), .err_count(err_count)
  );

  function automatic logic [63:0] init_val(input logic [63:0] idx);
    case (idx)
      64'd3:   return 64'h1111_1111_1111_1111;
      64'd5:   return 64'h5555_5555_5555_5555;
      64'h10:  return 64'hDEAD_BEEF_00C0_FFEE;
      64'h20:  return 64'h2020_2020_2020_2020;
      64'h21:  return 64'h2121_2121_2121_2121;
      default: return 64'h0;
    endcase
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory environment: registered read, masked write, preload port.
  always @(posedge clock) begin
    if (ld_en) ram[ld_idx[7:0]] <= init_val(ld_idx);
    if (mem_w_enable)
      ram[mem_w_index[7:0]] <= (ram[mem_w_index[7:0]] & ~mem_w_mask) | (mem_w_data & mem_w_mask);
    if (mem_r_enable) mem_r_data <= ram[mem_r_index[7:0]];
  end

  // Reference model: per-requester pending response, round-robin pointer, flat memory.
  initial begin : model
    logic [N-1:0]  pend;
    logic [63:0]   pdata [N];
    logic [N-1:0]  perr;
    int            mptr;
    int            win;
    int            idx;
    logic [31:0]   ecnt;
    logic [N-1:0]  elig;
    logic [N-1:0]  exp_ready;
    logic [63:0]   widx, wdat, wmsk;
    logic          wr, oor;
    pend = '0; perr = '0; mptr = 0; ecnt = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    for (int j = 0; j < 5; j++) ref_mem[PRE_IDX[j]] = init_val(PRE_IDX[j]);
    forever begin
      @(negedge clock);
      if (preset_now) ecnt = 32'hFFFF_FFFE;
      if (!reset) begin
        chk("rst_req_ready", 128'(bus.req_ready), 128'd0);
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        chk("rst_rsp_err", 128'(bus.rsp_err), 128'd0);
        chk("rst_rsp_data", 128'(bus.rsp_data), 128'd0);
        chk("rst_mem_en", {mem_enable, mem_r_enable, mem_w_enable}, 128'd0);
        chk("rst_err_count", 128'(err_count), 128'd0);
        pend = '0; mptr = 0; ecnt = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("rsp_valid%0d", i), 128'(bus.rsp_valid[i]), 128'(pend[i]));
          if (pend[i]) begin
            chk($sformatf("rsp_data%0d", i), 128'(bus.rsp_data[i*64 +: 64]), 128'(pdata[i]));
            chk($sformatf("rsp_err%0d", i), 128'(bus.rsp_err[i]), 128'(perr[i]));
          end
        end
        elig = bus.req_valid & ~pend;
        win = -1;
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (win < 0 && elig[idx]) win = idx;
        end
        exp_ready = '0;
        wr = 1'b0; oor = 1'b0; widx = '0; wdat = '0; wmsk = '0;
        if (win >= 0) begin
          exp_ready[win] = 1'b1;
          wr   = bus.req_write[win];
          widx = bus.req_index[win*64 +: 64];
          wdat = bus.req_wdata[win*64 +: 64];
          wmsk = bus.req_wmask[win*64 +: 64];
          oor  = (widx >= RW);
        end
        chk("req_ready", 128'(bus.req_ready), 128'(exp_ready));
        chk("mem_enable", 128'(mem_enable), 128'd1);
        chk("mem_r_enable", 128'(mem_r_enable), 128'(win >= 0 && !wr && !oor));
        chk("mem_r_index", 128'(mem_r_index), (win >= 0 && !wr && !oor) ? 128'(widx) : 128'd0);
        chk("mem_w_enable", 128'(mem_w_enable), 128'(win >= 0 && wr && !oor));
        chk("mem_w_bus", {mem_w_index, mem_w_data ^ mem_w_mask},
            (win >= 0 && wr && !oor) ? {widx, wdat ^ wmsk} : 128'd0);
        chk("mem_w_mask", 128'(mem_w_mask), (win >= 0 && wr && !oor) ? 128'(wmsk) : 128'd0);
        chk("err_count", 128'(err_count), 128'(ecnt));
        for (int i = 0; i < N; i++) if (pend[i] && bus.rsp_ready[i]) pend[i] = 1'b0;
        if (win >= 0) begin
          pend[win] = 1'b1;
          perr[win] = oor;
          pdata[win] = '0;
          if (oor) begin
            if (ecnt != 32'hFFFF_FFFF) ecnt = ecnt + 1;
          end else if (wr) begin
            ref_mem[widx] = ((ref_mem.exists(widx) ? ref_mem[widx] : 64'h0) & ~wmsk) | (wdat & wmsk);
          end else begin
            pdata[win] = ref_mem.exists(widx) ? ref_mem[widx] : 64'h0;
          end
          mptr = (win + 1) % N;
        end
      end
    end
  end

  task automatic drive(input int i, input logic wr, input logic [63:0] idx, input logic [63:0] wd,
                       input logic [63:0] wm);
    bus.req_valid[i]         = 1'b1;
    bus.req_write[i]         = wr;
    bus.req_index[i*64 +: 64] = idx;
    bus.req_wdata[i*64 +: 64] = wd;
    bus.req_wmask[i*64 +: 64] = wm;
  endtask

  // Presents one request, returns at T+1 (+1 time unit) with the mem strobes seen in grant cycle T.
  task automatic issue(input int i, input logic wr, input logic [63:0] idx, input logic [63:0] wd,
                       input logic [63:0] wm, output logic ren, output logic wen, output logic [63:0] ridx);
    logic done;
    done = 1'b0; ren = 1'b0; wen = 1'b0; ridx = '0;
    @(posedge clock); #1;
    drive(i, wr, idx, wd, wm);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (bus.req_ready[i]) begin
        done = 1'b1; ren = mem_r_enable; wen = mem_w_enable; ridx = mem_r_index;
      end
    end
    chk("grant_within_budget", 128'(done), 128'd1);
    @(posedge clock); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input logic [63:0] exp_d, input logic exp_e, input string nm);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
        done = 1'b1;
        chk({nm, "_data"}, 128'(bus.rsp_data[i*64 +: 64]), 128'(exp_d));
        chk({nm, "_err"}, 128'(bus.rsp_err[i]), 128'(exp_e));
      end
    end
    chk({nm, "_arrived"}, 128'(done), 128'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        ren, wen;
    logic [63:0] ridx;
    logic [N-1:0] seen [8];
    int          rcount, g1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_index = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_ready = '1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clock); #1;
      ld_en = 1'b1; ld_idx = PRE_IDX[j];
    end
    @(posedge clock); #1;
    ld_en = 1'b0;
    chk("lit_rst_mem_enable", 128'(mem_enable), 128'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Reset while a read is in flight: its response must vanish.
    issue(0, 1'b0, 64'd5, '0, '0, ren, wen, ridx);
    reset = 1'b0;
    @(negedge clock);
    chk("lit_midflight_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Round-robin from a fresh pointer: 0,1,0,1 with a read every cycle.
    @(posedge clock); #1;
    drive(0, 1'b0, 64'h20, '0, '0);
    drive(1, 1'b0, 64'h21, '0, '0);
    rcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      seen[c] = bus.req_ready;
      if (mem_r_enable) rcount++;
    end
    @(posedge clock); #1;
    bus.req_valid = '0;
    for (int c = 0; c < 8; c++) chk($sformatf("lit_rr_grant%0d", c), 128'(seen[c]), (c % 2 == 0) ? 128'd1 : 128'd2);
    chk("lit_rr_reads", 128'(rcount), 128'd8);
    chk("lit_err_after_reset", 128'(err_count), 128'd0);

    // Single read.
    issue(0, 1'b0, 64'h10, '0, '0, ren, wen, ridx);
    chk("lit_read_ren", 128'(ren), 128'd1);
    chk("lit_read_ridx", 128'(ridx), 128'h10);
    wait_rsp(0, 64'hDEAD_BEEF_00C0_FFEE, 1'b0, "lit_read");

    // Masked write then read back.
    issue(1, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, ren, wen, ridx);
    chk("lit_write_wen", 128'(wen), 128'd1);
    wait_rsp(1, 64'h0, 1'b0, "lit_write");
    issue(0, 1'b0, 64'd3, '0, '0, ren, wen, ridx);
    wait_rsp(0, 64'h1111_1111_FFFF_1111, 1'b0, "lit_rmw");

    // Backpressure on requester 0 while requester 1 streams.
    @(posedge clock); #1;
    bus.rsp_ready[0] = 1'b0;
    drive(1, 1'b0, 64'h21, '0, '0);
    issue(0, 1'b0, 64'h10, '0, '0, ren, wen, ridx);
    drive(0, 1'b0, 64'h10, '0, '0);
    g1 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("lit_hold_data%0d", c), {63'd0, bus.rsp_valid[0], bus.rsp_data[63:0]},
          {63'd0, 1'b1, 64'hDEAD_BEEF_00C0_FFEE});
      chk($sformatf("lit_hold_ready%0d", c), 128'(bus.req_ready[0]), 128'd0);
      if (bus.req_ready[1]) g1++;
    end
    chk("lit_hold_req1_grants", 128'(g1), 128'd2);
    @(posedge clock); #1;
    bus.req_valid = '0;
    bus.rsp_ready[0] = 1'b1;
    wait_rsp(0, 64'hDEAD_BEEF_00C0_FFEE, 1'b0, "lit_release");
    repeat (3) @(posedge clock);

    // Range checks, including a last-valid-index write and a high-bit index.
    issue(0, 1'b1, RW - 64'd1, 64'hA5A5_A5A5_A5A5_A5A5, '1, ren, wen, ridx);
    chk("lit_last_index_wen", 128'(wen), 128'd1);
    wait_rsp(0, 64'h0, 1'b0, "lit_last_index");
    issue(0, 1'b0, 64'h2000_0000, '0, '0, ren, wen, ridx);
    chk("lit_oor_no_enable", {ren, wen}, 128'd0);
    wait_rsp(0, 64'h0, 1'b1, "lit_oor");
    chk("lit_err_count1", 128'(err_count), 128'd1);
    issue(1, 1'b1, 64'h0000_0001_0000_0005, '1, '1, ren, wen, ridx);
    chk("lit_oor_hi_no_enable", {ren, wen}, 128'd0);
    wait_rsp(1, 64'h0, 1'b1, "lit_oor_hi");
    chk("lit_err_count2", 128'(err_count), 128'd2);

    // Saturation of the error counter.
    @(posedge clock); #2;
    force dut.err_cnt = 32'hFFFF_FFFE;
    preset_now = 1'b1;
    #1 release dut.err_cnt;
    @(posedge clock); #2;
    preset_now = 1'b0;
    issue(0, 1'b0, 64'h3000_0000, '0, '0, ren, wen, ridx);
    wait_rsp(0, 64'h0, 1'b1, "lit_sat_a");
    chk("lit_err_sat_a", 128'(err_count), 128'hFFFF_FFFF);
    issue(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0, ren, wen, ridx);
    wait_rsp(1, 64'h0, 1'b1, "lit_sat_b");
    chk("lit_err_sat_b", 128'(err_count), 128'hFFFF_FFFF);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_rw_arbiter.md
Name: mem_rw_arbiter

Overview:
- Shares the single read/write port pair of the checkpoint memory helper between N_REQ independent requesters, for example the core memory port and a checkpoint or DMA loader.
- Each request is one 64-bit word access.
- Arbitration is round-robin, one access is issued per cycle, and each requester gets a response.
- Indexes beyond the RAM size are range-checked and answered with an error response. They are never forwarded, so the memory's fatal trap cannot fire.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- RAM_WORDS, 536870912, valid 64-bit word indexes are 0..RAM_WORDS-1 (4 GiB).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request i valid.
- req_ready  out  N_REQ  request i accepted this cycle (grant).
- req_write  in  N_REQ  1 = write, 0 = read.
- req_index  in  N_REQ*64  word index, slice i = [64i+63:64i].
- req_wdata  in  N_REQ*64  write data.
- req_wmask  in  N_REQ*64  per-bit write mask.
- rsp_valid  out  N_REQ  response i valid.
- rsp_ready  in  N_REQ  response i consumed.
- rsp_data  out  N_REQ*64  read data; 0 for writes and errors.
- rsp_err  out  N_REQ  index out of range.
- mem_enable  out  1  memory enable: 1 when reset is deasserted, 0 during reset.
- mem_r_enable  out  1  memory read enable.
- mem_r_index  out  64  memory read index.
- mem_r_data  in  64  memory read data, registered by the memory, valid the cycle after mem_r_enable.
- mem_w_enable  out  1  memory write enable.
- mem_w_index  out  64  memory write index.
- mem_w_data  out  64  memory write data.
- mem_w_mask  out  64  memory write mask.
- err_count  out  32  saturating count of out-of-range requests.

Behaviour:
- Reset (reset=0, async):
  - All slots FREE; rr_ptr=0; err_count=0.
  - All outputs 0: req_ready, rsp_valid, rsp_err, rsp_data, mem_*_enable.
  - Any in-flight response is discarded.
- Per-requester slot FSM, states FREE / INFLIGHT / HELD:
  - FREE -> INFLIGHT on grant.
  - INFLIGHT: rsp_valid=1 this cycle. rsp_ready=1 -> FREE. rsp_ready=0 -> HELD, capturing rsp_data and rsp_err into a per-slot buffer.
  - HELD: rsp_valid=1 from the buffer. rsp_ready=1 -> FREE.
- Eligibility: requester i is eligible iff req_valid[i]=1 and its slot is FREE at the start of the cycle.
  - A requester whose slot frees this cycle is not regranted until the next cycle.
  - Per-requester throughput is therefore at most 1 per 2 cycles; the aggregate is 1 per cycle.
- Arbitration is combinational round-robin. The search starts at rr_ptr and wraps modulo N_REQ.
  - Exactly one req_ready is high when any requester is eligible.
  - After a grant to i, rr_ptr <= (i+1) mod N_REQ. rr_ptr is unchanged when there is no grant.
- Issue, in the grant cycle T (mem ports are driven combinationally from the winner):
  - In-range read: mem_r_enable=1, mem_r_index=index.
  - In-range write: mem_w_enable=1 with mem_w_index/mem_w_data/mem_w_mask from the winner.
  - Out of range (index >= RAM_WORDS, compared over the full 64 bits): no mem enable; err_count increments, saturating at 0xFFFFFFFF.
  - At most one of mem_r_enable or mem_w_enable is high in any cycle.
- Response, cycle T+1:
  - Read OK: rsp_data=mem_r_data, rsp_err=0.
  - Write OK: rsp_data=0, rsp_err=0.
  - Error: rsp_data=0, rsp_err=1.
  - mem_r_data is sampled only in the INFLIGHT cycle of a read slot.
- Ordering:
  - A write granted at T is visible to a read granted at T+1 or later.
  - Responses are per-requester and in order, because each requester has at most one outstanding access.
- Idle mem index/data/mask outputs are 0. All outputs are deterministic; no X is propagated out of any output.

Test Plan:
- Reset mid-flight: requester 0 reads index 5; assert reset at T+1 -> rsp_valid=0. After reset release, rr_ptr=0 and err_count=0, and no spurious response appears.
- Single read: mem pre-loaded word 0x10 = 0xDEADBEEF_00C0FFEE. Req0 read index 0x10 at T -> mem_r_enable=1 and mem_r_index=0x10 at T; rsp_valid[0]=1 with that data at T+1.
- Masked write then read: Req1 writes index 3, data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0000_0000_FFFF_0000, over old 0x1111_1111_1111_1111. A following read returns 0x1111_1111_FFFF_1111.
- Round-robin: both requesters hold reads continuously with rsp_ready=1. Grants alternate 0,1,0,1, with one mem_r_enable per cycle over 8 cycles.
- Backpressure: req0 read with rsp_ready[0]=0 for 3 cycles -> rsp_valid[0] held with stable data, req_ready[0]=0 throughout, and req1 still granted every other cycle. Data is delivered when rsp_ready[0] rises.
- Out of range: req0 index 0x2000_0000 -> no mem enable, rsp_err[0]=1 and rsp_data=0 at T+1, err_count=1. With err_count preset near saturation it stays at 0xFFFFFFFF.
